// File: rtl/fir_mac_serial.sv
// fir_mac_serial: time-multiplexed FIR filter with one shared MAC,
// run-time loadable coefficients and a saturating output stage.
module fir_mac_serial #(
   parameter  int WW_INPUT  = 8,
   parameter  int WW_COEFF  = 8,
   parameter  int WW_OUTPUT = 8,
   parameter  int N_TAPS    = 15,
   parameter  int OUT_SHIFT = 7,
   localparam int WW_ADDR   = $clog2(N_TAPS)
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_valid,
   input  logic signed [WW_INPUT-1:0]  i_signal,
   output logic                        o_ready,
   input  logic                        i_coeff_we,
   input  logic        [WW_ADDR-1:0]   i_coeff_addr,
   input  logic signed [WW_COEFF-1:0]  i_coeff_data,
   output logic                        o_valid,
   output logic signed [WW_OUTPUT-1:0] o_signal,
   output logic                        o_overflow
);

   localparam int WW_PROD = WW_INPUT + WW_COEFF;
   localparam int WW_ACC  = WW_PROD + $clog2(N_TAPS);

   localparam logic [WW_ADDR-1:0] LAST    = WW_ADDR'(N_TAPS - 1);
   localparam logic [WW_ADDR:0]   NTAPS_W = (WW_ADDR + 1)'(N_TAPS);

   localparam logic signed [WW_ACC-1:0] SAT_MAX =
      {{(WW_ACC - WW_OUTPUT + 1){1'b0}}, {(WW_OUTPUT - 1){1'b1}}};
   localparam logic signed [WW_ACC-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_OUT
   } state_t;

   state_t state_q;

   logic signed [WW_INPUT-1:0] hist_q  [N_TAPS];
   logic signed [WW_COEFF-1:0] coeff_q [N_TAPS];

   logic [WW_ADDR-1:0] wr_ptr_q;
   logic [WW_ADDR-1:0] rd_ptr_q;
   logic [WW_ADDR-1:0] k_q;

   logic signed [WW_ACC-1:0]  acc_q;
   logic signed [WW_ACC-1:0]  acc_d;
   logic signed [WW_ACC-1:0]  shifted;
   logic signed [WW_PROD-1:0] prod;

   logic                        o_valid_q;
   logic signed [WW_OUTPUT-1:0] o_signal_q;
   logic                        o_overflow_q;

   logic accept;
   logic coeff_wr;
   logic sat_hi;
   logic sat_lo;

   assign o_ready    = (state_q == ST_IDLE) && !i_reset;
   assign accept     = i_valid && o_ready;
   assign coeff_wr   = i_coeff_we && o_ready
                       && ({1'b0, i_coeff_addr} < NTAPS_W);

   assign prod  = hist_q[rd_ptr_q] * coeff_q[k_q];
   assign acc_d = acc_q
                  + {{(WW_ACC - WW_PROD){prod[WW_PROD-1]}}, prod};

   // Arithmetic shift floors toward -inf before the saturation test.
   assign shifted = acc_q >>> OUT_SHIFT;
   assign sat_hi  = shifted > SAT_MAX;
   assign sat_lo  = shifted < SAT_MIN;

   assign o_valid    = o_valid_q;
   assign o_signal   = o_signal_q;
   assign o_overflow = o_overflow_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         k_q          <= '0;
         acc_q        <= '0;
         o_valid_q    <= 1'b0;
         o_signal_q   <= '0;
         o_overflow_q <= 1'b0;
         for (int i = 0; i < N_TAPS; i++) begin
            hist_q[i]  <= '0;
            coeff_q[i] <= '0;
         end
      end else begin
         o_valid_q <= 1'b0;
         if (coeff_wr) begin
            coeff_q[i_coeff_addr] <= i_coeff_data;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  hist_q[wr_ptr_q] <= i_signal;
                  rd_ptr_q         <= wr_ptr_q;
                  k_q              <= '0;
                  acc_q            <= '0;
                  state_q          <= ST_MAC;
               end
            end
            ST_MAC: begin
               acc_q <= acc_d;
               k_q   <= k_q + WW_ADDR'(1);
               // Walk backwards through the circular history.
               rd_ptr_q <= (rd_ptr_q == '0) ? LAST
                                            : rd_ptr_q - WW_ADDR'(1);
               if (k_q == LAST) begin
                  wr_ptr_q <= (wr_ptr_q == LAST) ? '0
                                                 : wr_ptr_q + WW_ADDR'(1);
                  state_q  <= ST_OUT;
               end
            end
            ST_OUT: begin
               o_valid_q <= 1'b1;
               if (sat_hi) begin
                  o_signal_q   <= SAT_MAX[WW_OUTPUT-1:0];
                  o_overflow_q <= 1'b1;
               end else if (sat_lo) begin
                  o_signal_q   <= SAT_MIN[WW_OUTPUT-1:0];
                  o_overflow_q <= 1'b1;
               end else begin
                  o_signal_q   <= shifted[WW_OUTPUT-1:0];
                  o_overflow_q <= 1'b0;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_serial.sv
// tb_fir_mac_serial: directed tests for the serial FIR MAC using a
// wide unshifted instance (A) and a default saturating instance (B).
module tb_fir_mac_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic               a_valid, a_ready, a_we, a_ovalid, a_ov;
   logic signed [7:0]  a_sig, a_data;
   logic [3:0]         a_addr;
   logic signed [15:0] a_osig;

   logic               b_valid, b_ready, b_we, b_ovalid, b_ov;
   logic signed [7:0]  b_sig, b_data;
   logic [3:0]         b_addr;
   logic signed [7:0]  b_osig;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] ctab [15] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h03,
                             8'h08, 8'h0D, 8'h10, 8'h0D, 8'h08,
                             8'h03, 8'h00, 8'hFF, 8'hFF, 8'hFF};
   int exp_imp [16] = '{-1, -1, -1, 0, 3, 8, 13, 16,
                        13, 8, 3, 0, -1, -1, -1, 0};

   fir_mac_serial #(
      .WW_OUTPUT(16),
      .OUT_SHIFT(0)
   ) dut_a (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_valid     (a_valid),
      .i_signal    (a_sig),
      .o_ready     (a_ready),
      .i_coeff_we  (a_we),
      .i_coeff_addr(a_addr),
      .i_coeff_data(a_data),
      .o_valid     (a_ovalid),
      .o_signal    (a_osig),
      .o_overflow  (a_ov)
   );

   fir_mac_serial dut_b (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_valid     (b_valid),
      .i_signal    (b_sig),
      .o_ready     (b_ready),
      .i_coeff_we  (b_we),
      .i_coeff_addr(b_addr),
      .i_coeff_data(b_data),
      .o_valid     (b_ovalid),
      .o_signal    (b_osig),
      .o_overflow  (b_ov)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wr_a(input logic [3:0] addr, input logic [7:0] d);
      a_we   = 1'b1;
      a_addr = addr;
      a_data = d;
      tick();
      a_we = 1'b0;
   endtask

   task automatic wr_b(input logic [3:0] addr, input logic [7:0] d);
      b_we   = 1'b1;
      b_addr = addr;
      b_data = d;
      tick();
      b_we = 1'b0;
   endtask

   task automatic wait_a(output logic signed [15:0] y, output logic ov);
      int n = 0;
      while (!a_ovalid && n < 100) begin
         tick();
         n++;
      end
      if (!a_ovalid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_a timeout: o_valid=0 required 1");
      end
      y  = a_osig;
      ov = a_ov;
   endtask

   task automatic send_a(input logic signed [7:0] x,
                         output logic signed [15:0] y, output logic ov);
      int n = 0;
      a_valid = 1'b1;
      a_sig   = x;
      while (!a_ready && n < 100) begin
         tick();
         n++;
      end
      tick();
      a_valid = 1'b0;
      wait_a(y, ov);
   endtask

   task automatic send_b(input logic signed [7:0] x,
                         output logic signed [7:0] y, output logic ov);
      int n = 0;
      b_valid = 1'b1;
      b_sig   = x;
      while (!b_ready && n < 100) begin
         tick();
         n++;
      end
      tick();
      b_valid = 1'b0;
      n = 0;
      while (!b_ovalid && n < 100) begin
         tick();
         n++;
      end
      if (!b_ovalid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_b timeout: o_valid=0 required 1");
      end
      y  = b_osig;
      ov = b_ov;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (a_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_ready: got %b required 0", a_ready);
      end
      n_cmp++;
      if (a_ovalid !== 1'b0 || b_ovalid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_valid: got %b/%b required 0", a_ovalid, b_ovalid);
      end
      n_cmp++;
      if (a_osig !== 16'sd0 || b_osig !== 8'sd0) begin
         n_bad++;
         $display("FAIL rst_signal: got %0d/%0d required 0", a_osig, b_osig);
      end
      n_cmp++;
      if (a_ov !== 1'b0 || b_ov !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_overflow: got %b/%b required 0", a_ov, b_ov);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_release_ready: got %b/%b required 1", a_ready, b_ready);
      end
   endtask

   task automatic test_impulse;
      logic signed [15:0] y;
      logic ov;
      do_reset();
      for (int i = 0; i < 15; i++) wr_a(4'(i), ctab[i]);
      for (int i = 0; i < 16; i++) begin
         send_a((i == 0) ? 8'sd1 : 8'sd0, y, ov);
         n_cmp++;
         if (y !== 16'(exp_imp[i]) || ov !== 1'b0) begin
            n_bad++;
            $display("FAIL impulse[%0d]: got %0d ovf %b required %0d ovf 0",
                     i, y, ov, exp_imp[i]);
         end
      end
   endtask

   task automatic test_saturate;
      logic signed [7:0] y;
      logic ov;
      do_reset();
      for (int i = 0; i < 15; i++) wr_b(4'(i), 8'h7F);
      for (int i = 0; i < 15; i++) begin
         send_b(8'sd127, y, ov);
         if (i == 0) begin
            n_cmp++;
            if (y !== 8'sd126 || ov !== 1'b0) begin
               n_bad++;
               $display("FAIL sat_first: got %0d ovf %b required 126 ovf 0", y, ov);
            end
         end
      end
      n_cmp++;
      if (y !== 8'sd127 || ov !== 1'b1) begin
         n_bad++;
         $display("FAIL sat_pos: got %0d ovf %b required 127 ovf 1", y, ov);
      end
      for (int i = 0; i < 15; i++) send_b(-8'sd128, y, ov);
      n_cmp++;
      if (y !== -8'sd128 || ov !== 1'b1) begin
         n_bad++;
         $display("FAIL sat_neg: got %0d ovf %b required -128 ovf 1", y, ov);
      end
      do_reset();
      wr_b(4'd0, 8'h01);
      send_b(-8'sd1, y, ov);
      n_cmp++;
      if (y !== -8'sd1 || ov !== 1'b0) begin
         n_bad++;
         $display("FAIL shift_floor: got %0d ovf %b required -1 ovf 0", y, ov);
      end
      send_b(8'sd127, y, ov);
      n_cmp++;
      if (y !== 8'sd0 || ov !== 1'b0) begin
         n_bad++;
         $display("FAIL shift_trunc: got %0d ovf %b required 0 ovf 0", y, ov);
      end
   endtask

   task automatic test_back_to_back;
      int n_in = 0;
      int n_out = 0;
      int low = 0;
      int last = 0;
      logic r;
      do_reset();
      wr_a(4'd0, 8'h01);
      a_valid = 1'b1;
      a_sig   = 8'sd1;
      for (int cyc = 0; cyc < 600 && n_out < 20; cyc++) begin
         r = a_ready;
         tick();
         if (r && a_valid) begin
            n_in++;
            if (n_in == 20) a_valid = 1'b0;
            else a_sig = 8'(n_in + 1);
         end
         if (!a_ready) begin
            low++;
         end else if (low != 0) begin
            n_cmp++;
            if (low != 16) begin
               n_bad++;
               $display("FAIL b2b_ready_low: got %0d cycles required 16", low);
            end
            low = 0;
         end
         if (a_ovalid) begin
            n_cmp++;
            if (a_osig !== 16'(n_out + 1)) begin
               n_bad++;
               $display("FAIL b2b_value[%0d]: got %0d required %0d",
                        n_out, a_osig, n_out + 1);
            end
            if (n_out > 0) begin
               n_cmp++;
               if (cyc - last != 17) begin
                  n_bad++;
                  $display("FAIL b2b_period: got %0d required 17", cyc - last);
               end
            end
            last = cyc;
            n_out++;
         end
      end
      a_valid = 1'b0;
      n_cmp++;
      if (n_in != 20 || n_out != 20) begin
         n_bad++;
         $display("FAIL b2b_count: got %0d in %0d out required 20/20", n_in, n_out);
      end
   endtask

   task automatic test_busy_write;
      logic signed [15:0] y;
      logic ov;
      do_reset();
      a_valid = 1'b1;
      a_sig   = 8'sd1;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      a_we   = 1'b1;
      a_addr = 4'd0;
      a_data = 8'h10;
      tick();
      a_we = 1'b0;
      wait_a(y, ov);
      n_cmp++;
      if (y !== 16'sd0) begin
         n_bad++;
         $display("FAIL busy_write_cur: got %0d required 0", y);
      end
      send_a(8'sd1, y, ov);
      n_cmp++;
      if (y !== 16'sd0) begin
         n_bad++;
         $display("FAIL busy_write_next: got %0d required 0", y);
      end
      wr_a(4'd0, 8'h10);
      send_a(8'sd1, y, ov);
      n_cmp++;
      if (y !== 16'sd16) begin
         n_bad++;
         $display("FAIL idle_write: got %0d required 16", y);
      end
      a_valid = 1'b1;
      a_sig   = 8'sd3;
      a_we    = 1'b1;
      a_addr  = 4'd0;
      a_data  = 8'h02;
      tick();
      a_valid = 1'b0;
      a_we    = 1'b0;
      wait_a(y, ov);
      n_cmp++;
      if (y !== 16'sd6) begin
         n_bad++;
         $display("FAIL write_with_accept: got %0d required 6", y);
      end
   endtask

   task automatic test_reset_mid;
      logic signed [15:0] y;
      logic ov;
      logic seen = 1'b0;
      do_reset();
      wr_a(4'd0, 8'h05);
      a_valid = 1'b1;
      a_sig   = 8'sd1;
      tick();
      a_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (a_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_rst_ready: got %b required 0", a_ready);
      end
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (a_ovalid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_rst_valid: got %b required 0", seen);
      end
      n_cmp++;
      if (a_osig !== 16'sd0) begin
         n_bad++;
         $display("FAIL mid_rst_signal: got %0d required 0", a_osig);
      end
      send_a(8'sd1, y, ov);
      n_cmp++;
      if (y !== 16'sd0) begin
         n_bad++;
         $display("FAIL mid_rst_coeffs: got %0d required 0", y);
      end
   endtask

   task automatic test_wrap;
      logic signed [15:0] y;
      logic ov;
      int e;
      do_reset();
      for (int i = 0; i < 15; i++) wr_a(4'(i), 8'h01);
      for (int n = 0; n < 40; n++) begin
         send_a(8'(n), y, ov);
         e = (n < 15) ? n * (n + 1) / 2 : 15 * n - 105;
         n_cmp++;
         if (y !== 16'(e) || ov !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap[%0d]: got %0d ovf %b required %0d ovf 0",
                     n, y, ov, e);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_sig = '0; a_we = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_sig = '0; b_we = 1'b0; b_addr = '0; b_data = '0;
      test_reset();
      test_impulse();
      test_saturate();
      test_back_to_back();
      test_busy_write();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fir_mac_serial.md
Name: fir_mac_serial

Overview:
- Time-multiplexed FIR filter: one shared multiplier-accumulator iterates over N_TAPS taps per input sample.
- Coefficients are run-time loadable through a write port; the fixed-coefficient parallel filter is replaced by this block on BRAM-fed signal paths.
- Valid/ready handshake on the input, single-cycle valid pulse on the output.
- Output is arithmetically shifted, then saturated to WW_OUTPUT, with an overflow flag.

Parameters:
- WW_INPUT, 8, signed input sample width.
- WW_COEFF, 8, signed coefficient width.
- WW_OUTPUT, 8, signed output width.
- N_TAPS, 15, number of taps; legal range 2..256.
- OUT_SHIFT, 7, fractional bits dropped from the accumulator before saturation; legal range 0..WW_ACC-WW_OUTPUT.
- Derived: WW_ACC = WW_INPUT+WW_COEFF+clog2(N_TAPS); WW_ADDR = clog2(N_TAPS).

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  input sample valid
- i_signal  in  WW_INPUT  signed input sample
- o_ready  out  1  block can accept a sample or a coefficient write
- i_coeff_we  in  1  coefficient write enable
- i_coeff_addr  in  WW_ADDR  tap index, 0..N_TAPS-1
- i_coeff_data  in  WW_COEFF  signed coefficient
- o_valid  out  1  one-cycle pulse, new output present
- o_signal  out  WW_OUTPUT  signed filtered output
- o_overflow  out  1  saturation occurred on the current output; valid with o_valid

Behaviour:
- Reset (i_reset is synchronous, active-high; clock is i_clock):
  - state IDLE; o_ready=0 while i_reset=1, then 1 from the first cycle after release.
  - o_valid=0, o_signal=0, o_overflow=0.
  - All coefficients=0, sample history=0, write pointer=0, accumulator=0.
- State IDLE:
  - o_ready=1.
  - Sample accept = i_valid & o_ready at edge E0: write i_signal into the circular history at wr_ptr, clear acc, k=0, go to MAC.
- State MAC:
  - Each edge: acc <= acc + coeff[k]*x[n-k], where x[n-k] = hist[(wr_ptr-k) mod N_TAPS]; k increments.
  - Edges E1..EN perform taps k=0..N_TAPS-1. At EN, wr_ptr advances (wraps N_TAPS-1 -> 0) and state goes to OUT.
- State OUT:
  - Edge E(N+1): s = acc >>> OUT_SHIFT (arithmetic shift, truncation toward -inf).
  - If s > 2^(WW_OUTPUT-1)-1: o_signal = max, o_overflow=1.
  - If s < -2^(WW_OUTPUT-1): o_signal = min, o_overflow=1.
  - Otherwise o_signal = s[WW_OUTPUT-1:0], o_overflow=0.
  - o_valid=1 for exactly that cycle; state goes to IDLE.
- Latency: o_valid is high in the cycle after edge E(N_TAPS+1).
- Throughput: one sample per N_TAPS+2 cycles.
- o_signal and o_overflow hold their value until the next o_valid.
- o_ready=0 in MAC and OUT. i_valid is ignored while busy; a held i_valid is accepted on the first IDLE cycle, exactly once per handshake.
- Coefficient write:
  - Takes effect only when i_coeff_we & o_ready; written at that edge and used from the next accepted sample.
  - Writes while busy are dropped. Writes with i_coeff_addr >= N_TAPS are dropped.
  - A write and a sample accept on the same edge: both occur; the new coefficient is already visible to that sample's MAC.
- Accumulator never overflows: WW_ACC covers N_TAPS worst-case products, including (-2^(WW_INPUT-1))*(-2^(WW_COEFF-1)).
- Reset asserted mid-MAC/OUT: computation aborted, no o_valid, all state re-initialised including history and coefficients.
- Product and sum are signed; operands are sign-extended to WW_ACC before the add.

Test Plan:
- Defaults except OUT_SHIFT=0, WW_OUTPUT=16.
  - Stimulus: load coeffs FF,FF,FF,00,03,08,0D,10,0D,08,03,00,FF,FF,FF; send sample 1 then 15 zeros.
  - Required: outputs -1,-1,-1,0,3,8,13,16,13,8,3,0,-1,-1,-1, then 0; o_overflow=0 throughout.
- Defaults (OUT_SHIFT=7).
  - Stimulus: all coeffs 0x7F, 15 samples of +127.
  - Required: 15th output acc=241935, s=1890 -> o_signal=127, o_overflow=1.
  - Then 15 samples of -128: final o_signal=-128, o_overflow=1.
- Handshake.
  - Stimulus: i_valid held high continuously.
  - Required: o_ready low for exactly N_TAPS+1=16 cycles per sample; o_valid pulses every 17 cycles; no sample duplicated or skipped (count 20 in -> 20 out).
- Coefficient write while busy.
  - Stimulus: write coeff[0]=0x10 during MAC.
  - Required: write dropped, next output unchanged.
  - Same write in IDLE, then sample 1: output reflects 16 in the tap-0 term.
- Reset mid-operation.
  - Stimulus: assert i_reset at MAC cycle 5.
  - Required: no o_valid; o_signal=0; after release an impulse with all-zero coeffs gives output 0.
- Wrap-around.
  - Stimulus: 40 samples of ramp 0..39, coeffs all 1, OUT_SHIFT=0, WW_OUTPUT=16.
  - Required: output n = sum of the last 15 inputs (e.g. n=39 -> 480), with correct values across pointer wrap.
